// File: rtl/period_line_readout.sv
// period_line_readout
//
// Serialises one image line of measured pixel periods. On CAPTURE (while idle)
// the flat PERIOD_IN bus is snapshotted into a shadow register. The snapshot is
// then shifted out one bit per accepted transfer under a SER_VALID/READY
// handshake. Pixel 0 goes first, and each word is sent MSB first.
//
// Optional feature macro: READOUT_ZERO_FLAG_EN
//   When defined, each word gains a leading flag bit. The flag is 1 when that
//   pixel's period is zero, meaning no edge was measured.
//
// Parameters
//   PIXELS        pixels per line (>= 1)
//   COUNTER_BITS  width of each period value (>= 2)
//
// Ports
//   CLK          rising-edge clock
//   RST_N        synchronous active-low reset
//   CAPTURE      single-cycle request to snapshot PERIOD_IN and start a line
//   PERIOD_IN    pixel i occupies [i*COUNTER_BITS +: COUNTER_BITS]
//   READY        downstream accepts the current bit
//   SER_OUT      serial data bit (0 when idle)
//   SER_VALID    SER_OUT holds a valid bit
//   FRAME_START  high while the first bit of a line is presented
//   BUSY         high while a line is being transmitted
//   LINE_DONE    one-cycle pulse after the final bit transfers
//   OVERRUN      sticky; set by CAPTURE while busy, cleared only by reset
module period_line_readout #(
    parameter int unsigned PIXELS       = 4,
    parameter int unsigned COUNTER_BITS = 15
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           CAPTURE,
    input  logic [PIXELS*COUNTER_BITS-1:0] PERIOD_IN,
    input  logic                           READY,
    output logic                           SER_OUT,
    output logic                           SER_VALID,
    output logic                           FRAME_START,
    output logic                           BUSY,
    output logic                           LINE_DONE,
    output logic                           OVERRUN
);

`ifdef READOUT_ZERO_FLAG_EN
    localparam int unsigned WORD_BITS = COUNTER_BITS + 1;
`else
    localparam int unsigned WORD_BITS = COUNTER_BITS;
`endif
    localparam int unsigned LINE_BITS = PIXELS * WORD_BITS;
    localparam int unsigned CNT_BITS  = (LINE_BITS > 1) ? $clog2(LINE_BITS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(LINE_BITS - 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t                state_q, state_d;
    logic [LINE_BITS-1:0]  shadow_q;
    logic [CNT_BITS-1:0]   bit_cnt_q;
    logic                  line_done_q;
    logic                  overrun_q;

    logic [LINE_BITS-1:0]  load_word;
    logic                  transfer;
    logic                  last_transfer;

    // Pixel 0 is packed into the top of the shadow register, so the next bit
    // to send is always the register MSB and a transfer is a plain left shift.
    always_comb begin
        load_word = '0;
        for (int i = 0; i < PIXELS; i++) begin
`ifdef READOUT_ZERO_FLAG_EN
            load_word[(PIXELS-1-i)*WORD_BITS +: WORD_BITS] =
                {(PERIOD_IN[i*COUNTER_BITS +: COUNTER_BITS] == '0),
                 PERIOD_IN[i*COUNTER_BITS +: COUNTER_BITS]};
`else
            load_word[(PIXELS-1-i)*WORD_BITS +: WORD_BITS] =
                PERIOD_IN[i*COUNTER_BITS +: COUNTER_BITS];
`endif
        end
    end

    // Next-state and output decode. All outputs depend only on registered
    // state, so no path runs from READY or CAPTURE to any output.
    always_comb begin
        state_d       = state_q;
        transfer      = 1'b0;
        last_transfer = 1'b0;
        SER_OUT       = 1'b0;
        SER_VALID     = 1'b0;
        BUSY          = 1'b0;
        FRAME_START   = 1'b0;
        case (state_q)
            StIdle: begin
                if (CAPTURE) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                SER_VALID   = 1'b1;
                BUSY        = 1'b1;
                SER_OUT     = shadow_q[LINE_BITS-1];
                FRAME_START = (bit_cnt_q == '0);
                transfer    = READY;
                if (READY && (bit_cnt_q == LAST_BIT)) begin
                    last_transfer = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            bit_cnt_q   <= '0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_done_q <= last_transfer;
            if ((state_q == StIdle) && CAPTURE) begin
                shadow_q  <= load_word;
                bit_cnt_q <= '0;
            end else if (transfer) begin
                shadow_q <= {shadow_q[LINE_BITS-2:0], 1'b0};
                // Hold at the terminal count; the next capture reloads zero.
                if (!last_transfer) begin
                    bit_cnt_q <= bit_cnt_q + CNT_BITS'(1);
                end
            end
            // A capture while shifting is dropped; only the sticky flag records it.
            if ((state_q == StShift) && CAPTURE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign LINE_DONE = line_done_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_period_line_readout.sv
// tb_period_line_readout
//
// Scoreboard bench for period_line_readout. The stimulus process issues
// captures. Each accepted capture pushes the expected bit stream, computed
// from the pixel values, into a queue. A negedge monitor pops and compares
// every transferred bit and also checks the idle, stall, LINE_DONE and
// OVERRUN behaviour. A second small instance (1 pixel, 2-bit periods) covers
// the minimum-size configuration. Honours READOUT_ZERO_FLAG_EN.
module tb_period_line_readout;

    localparam int unsigned PIX = 4;
    localparam int unsigned CB  = 15;
`ifdef READOUT_ZERO_FLAG_EN
    localparam int unsigned WB  = CB + 1;
    localparam int unsigned WB2 = 3;
`else
    localparam int unsigned WB  = CB;
    localparam int unsigned WB2 = 2;
`endif
    localparam int unsigned LB = PIX * WB;

    typedef struct packed {
        logic val;
        logic first;
        logic last;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              CAPTURE;
    logic [PIX*CB-1:0] PERIOD_IN;
    logic              READY;
    logic              SER_OUT, SER_VALID, FRAME_START, BUSY, LINE_DONE, OVERRUN;

    logic       cap2;
    logic [1:0] per2;
    logic       ready2;
    logic       so2, sv2, fs2, busy2, ld2, ov2;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic overrun_exp = 1'b0;
    int   ready_mode = 0;

    always #5 CLK = ~CLK;

    period_line_readout #(.PIXELS(PIX), .COUNTER_BITS(CB)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .CAPTURE(CAPTURE), .PERIOD_IN(PERIOD_IN),
        .READY(READY), .SER_OUT(SER_OUT), .SER_VALID(SER_VALID),
        .FRAME_START(FRAME_START), .BUSY(BUSY), .LINE_DONE(LINE_DONE),
        .OVERRUN(OVERRUN)
    );

    period_line_readout #(.PIXELS(1), .COUNTER_BITS(2)) u_dut_small (
        .CLK(CLK), .RST_N(RST_N), .CAPTURE(cap2), .PERIOD_IN(per2),
        .READY(ready2), .SER_OUT(so2), .SER_VALID(sv2),
        .FRAME_START(fs2), .BUSY(busy2), .LINE_DONE(ld2), .OVERRUN(ov2)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: pixel 0 first, each word MSB first, optional zero flag leading.
    task automatic push_line(input logic [PIX*CB-1:0] data);
        for (int p = 0; p < PIX; p++) begin
            logic [CB-1:0] per;
            logic [WB-1:0] w;
            exp_t          e;
            per = data[p*CB +: CB];
`ifdef READOUT_ZERO_FLAG_EN
            w = {(per == 0), per};
`else
            w = per;
`endif
            for (int b = WB - 1; b >= 0; b--) begin
                e.val   = w[b];
                e.first = (p == 0) && (b == WB - 1);
                e.last  = (p == PIX - 1) && (b == 0);
                q.push_back(e);
            end
        end
    endtask

    // Called just after a rising edge. A capture is only accepted if no bits
    // of the current line are still outstanding.
    task automatic capture(input logic [PIX*CB-1:0] data);
        logic busy;
        busy      = (q.size() > 0);
        CAPTURE   = 1'b1;
        PERIOD_IN = data;
        @(posedge CLK);
        #1;
        CAPTURE = 1'b0;
        if (busy) overrun_exp = 1'b1;
        else      push_line(data);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_remaining(input int n);
        int budget;
        budget = 5000;
        while ((q.size() > n) && (budget > 0)) begin
            tick();
            budget--;
        end
        if (q.size() > n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_remaining: %0d bits left, wanted at most %0d", q.size(), n);
        end
    endtask

    function automatic logic [PIX*CB-1:0] rand_line();
        logic [PIX*CB-1:0] d;
        d = '0;
        for (int p = 0; p < PIX; p++) begin
            case ($urandom_range(0, 3))
                0:       d[p*CB +: CB] = '0;
                1:       d[p*CB +: CB] = '1;
                default: d[p*CB +: CB] = CB'($urandom);
            endcase
        end
        return d;
    endfunction

    // READY driver: 0 = always high, 1 = pattern 1,0,0,1, otherwise random.
    initial begin
        int cyc;
        cyc   = 0;
        READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            case (ready_mode)
                0:       READY = 1'b1;
                1:       READY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: READY = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor / scoreboard, sampling midway between rising edges.
    initial begin
        logic done_pending;
        logic stall_prev;
        logic prev_out;
        exp_t e;
        done_pending = 1'b0;
        stall_prev   = 1'b0;
        prev_out     = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                q.delete();
                done_pending = 1'b0;
                stall_prev   = 1'b0;
            end else begin
                check("ser_valid", SER_VALID, q.size() > 0);
                check("busy", BUSY, q.size() > 0);
                check("line_done", LINE_DONE, done_pending);
                check("overrun", OVERRUN, overrun_exp);
                if (stall_prev) check("stall_hold", SER_OUT, prev_out);
                done_pending = 1'b0;
                stall_prev   = 1'b0;
                if (q.size() == 0) begin
                    check("idle_ser_out", SER_OUT, 1'b0);
                    check("idle_frame_start", FRAME_START, 1'b0);
                end else begin
                    check("frame_start", FRAME_START, q[0].first);
                    if (READY) begin
                        e = q.pop_front();
                        check("ser_out", SER_OUT, e.val);
                        done_pending = e.last;
                    end else begin
                        stall_prev = 1'b1;
                        prev_out   = SER_OUT;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PIX*CB-1:0] basic;
        logic [PIX*CB-1:0] alt;
        logic [WB2-1:0]    w2;
        basic     = {15'h0000, 15'h1234, 15'h7FFF, 15'h0001};
        alt       = {15'h5555, 15'h0000, 15'h2AAA, 15'h7001};
        RST_N     = 1'b0;
        CAPTURE   = 1'b0;
        PERIOD_IN = '0;
        cap2      = 1'b0;
        per2      = 2'b00;
        ready2    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (2) tick();

        // Basic line, READY held high.
        ready_mode = 0;
        capture(basic);
        wait_remaining(0);
        repeat (3) tick();

        // Backpressure, READY 1,0,0,1 repeating.
        ready_mode = 1;
        capture(basic);
        wait_remaining(0);
        repeat (3) tick();

        // Overrun at bit 10 and on the final-transfer edge, then a capture in the LINE_DONE cycle.
        ready_mode = 0;
        tick();
        capture(basic);
        wait_remaining(LB - 10);
        capture(alt);
        wait_remaining(1);
        capture(alt);
        capture(alt);
        wait_remaining(0);
        repeat (3) tick();

        // Reset mid-line at bit 20, then a fresh line.
        capture(basic);
        wait_remaining(LB - 20);
        RST_N = 1'b0;
        tick();
        RST_N       = 1'b1;
        overrun_exp = 1'b0;
        repeat (2) tick();
        capture(basic);
        wait_remaining(0);
        repeat (3) tick();

        // Randomised lines with random backpressure and occasional overruns.
        ready_mode = 2;
        repeat (8) begin
            capture(rand_line());
            if ($urandom_range(0, 1) == 1) begin
                wait_remaining(int'($urandom_range(1, LB - 1)));
                capture(rand_line());
            end
            wait_remaining(0);
            repeat ($urandom_range(0, 2)) tick();
        end
        ready_mode = 0;
        repeat (3) tick();

        // Minimum configuration: one pixel, 2-bit period 0b10.
`ifdef READOUT_ZERO_FLAG_EN
        w2 = {1'b0, 2'b10};
`else
        w2 = 2'b10;
`endif
        cap2 = 1'b1;
        per2 = 2'b10;
        tick();
        cap2 = 1'b0;
        for (int i = 0; i < WB2; i++) begin
            @(negedge CLK);
            check("small_valid", sv2, 1'b1);
            check("small_bit", so2, w2[WB2-1-i]);
            check("small_frame_start", fs2, i == 0);
        end
        @(negedge CLK);
        check("small_line_done", ld2, 1'b1);
        check("small_valid_end", sv2, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/period_line_readout.md
# period_line_readout

Serial transmitter for one image line of measured pixel periods. It snapshots the flat `PERIOD` bus produced by the per-pixel `frequency_counter` array and shifts it out one bit per accepted cycle under a valid/ready handshake. It is the read side of the per-line measurement path: a pixel line is shifted in and converted to frequencies, the counters measure them, and this block streams the results off-chip.

## Interface
- `PIXELS`, default 4: number of pixels per line, ≥1.
- `COUNTER_BITS`, default 15: width of each period value, ≥2.
- `WORD_BITS`, derived and not overridable: `COUNTER_BITS`, or `COUNTER_BITS+1` with `READOUT_ZERO_FLAG_EN`.
- `CLK` in, 1: rising-edge clock.
- `RST_N` in, 1: synchronous active-low reset.
- `CAPTURE` in, 1: single-cycle request to snapshot `PERIOD_IN` and start a line.
- `PERIOD_IN` in, `PIXELS*COUNTER_BITS`: pixel i is bits `[i*COUNTER_BITS +: COUNTER_BITS]`.
- `READY` in, 1: downstream accepts the current bit.
- `SER_OUT` out, 1: serial data bit.
- `SER_VALID` out, 1: `SER_OUT` holds a valid bit.
- `FRAME_START` out, 1: high while the first bit of a line is presented.
- `BUSY` out, 1: high while a line is being transmitted.
- `LINE_DONE` out, 1: one-cycle pulse after the final bit transfers.
- `OVERRUN` out, 1: sticky flag, set when `CAPTURE` arrives while `BUSY`.

## Operation
- The FSM has two states, IDLE and SHIFT.
- In IDLE with `CAPTURE=1`:
  - latch all of `PERIOD_IN` into a shadow register;
  - bit counter ← 0;
  - go to SHIFT.
- In SHIFT:
  - `SER_VALID=1`, `BUSY=1`.
  - A transfer occurs on every edge where `SER_VALID && READY`; the shadow register then advances one bit and the bit counter increments.
  - `READY=0` holds `SER_OUT` and all state unchanged, with no limit on stall length.
- Bit order: pixel 0 first, then pixels 1 to `PIXELS-1`; each word is sent MSB first.
- When transfer number `PIXELS*WORD_BITS-1` (0-based) occurs, go to IDLE and pulse `LINE_DONE` in the next cycle.
- In IDLE, `SER_OUT=0`, `SER_VALID=0`, `BUSY=0`, `FRAME_START=0`.
- `FRAME_START = SER_VALID && (bit counter == 0)`. It stays high through stalls on bit 0.
- Overrun:
  - `CAPTURE` while in SHIFT, including on the edge of the final transfer, is ignored.
  - The shadow register is not modified, and `OVERRUN` is set to 1.
  - `OVERRUN` clears only on reset.
- `CAPTURE` during the `LINE_DONE` cycle is in IDLE, so it is accepted normally.
- The bit counter width is `$clog2(PIXELS*WORD_BITS)`, minimum 1. It never wraps past the terminal count.

## Timing
- Reset: `RST_N=0` sampled at an edge puts the FSM in IDLE and clears the shadow register, counter, `OVERRUN` and `LINE_DONE`.
  - All outputs read 0 from the cycle after that edge.
  - Reset mid-line aborts the line with no `LINE_DONE`.
- `CAPTURE` sampled at edge k: bit 0 (pixel 0 MSB) is on `SER_OUT`, with `SER_VALID=1` and `FRAME_START=1`, from cycle k+1.
- With `READY` held high, a line occupies exactly `PIXELS*WORD_BITS` cycles of `SER_VALID`. `LINE_DONE` appears in the following cycle, so the minimum capture-to-capture spacing is `PIXELS*WORD_BITS+1` cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from `READY` or `CAPTURE` to any output.

## Configuration
- Macro: `READOUT_ZERO_FLAG_EN`.
- Defined:
  - Each word is `COUNTER_BITS+1` bits; the leading bit is the zero flag.
  - The flag is 1 when that pixel's period equals 0 (no edge measured), else 0.
  - The flag is sent first, then the period MSB first.
- Undefined: words are the raw `COUNTER_BITS` period only, with no flag logic.

## Test plan
- **Basic line.** Defaults, flag off, `READY=1`, `PERIOD_IN` pixels {0:0x0001, 1:0x7FFF, 2:0x1234, 3:0x0000}, one `CAPTURE`.
  - Expect 60 bits starting `000000000000001`, then fifteen 1s, then `001001000110100`, then fifteen 0s.
  - `FRAME_START` only on bit 0; `LINE_DONE` one cycle after bit 59.
- **Backpressure.** Same data, `READY` toggling 1,0,0,1 repeating.
  - Bit sequence identical to the basic line; `SER_OUT` stable during stalls.
  - `LINE_DONE` after the 60th accepted transfer.
- **Overrun.** `CAPTURE` at bit 10 and again on the edge of the final transfer, with different `PERIOD_IN`.
  - Stream unchanged, `OVERRUN=1` and stays 1.
  - `CAPTURE` in the `LINE_DONE` cycle starts a new line.
- **Reset mid-line.** `RST_N=0` at bit 20.
  - Next cycle all outputs are 0 and there is no `LINE_DONE`.
  - A subsequent `CAPTURE` streams from pixel 0 MSB.
- **Zero flag** (`READOUT_ZERO_FLAG_EN` defined), same data as the basic line.
  - 64 bits; pixel 3 word = `1` followed by fifteen 0s; pixels 0–2 lead with `0`.
- **Boundary.** `PIXELS=1`, `COUNTER_BITS=2`, period 0b10.
  - Bits `1`,`0`, then `LINE_DONE`; the counter never exceeds 1.
